// File: rtl/vic_capture_pkg.sv
// Shared types for the VIC-II RGB capture block.
//   RGB_W / X_W / Y_W : field widths of a captured pixel
//   cap_word_t        : one tagged pixel {sof, eol, y, x, rgb}, 41 bits
package vic_capture_pkg;

    localparam int unsigned RGB_W = 18;
    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [Y_W-1:0]   y;
        logic [X_W-1:0]   x;
        logic [RGB_W-1:0] rgb;
    } cap_word_t;

    localparam int unsigned CAP_W = $bits(cap_word_t);

    localparam logic [X_W-1:0] X_MAX = '1;
    localparam logic [Y_W-1:0] Y_MAX = '1;

endpackage

// File: rtl/cap_sync_fifo.sv
// Single-clock FIFO for tagged pixels.
//   clk_dot4x, rst_n : clock, asynchronous active-low reset
//   push, din        : write request and data; accepted when not full or popping
//   pop              : read request; ignored when empty
//   dout             : head entry, forced to zero while empty
//   full, empty      : occupancy flags, driven from registers
module cap_sync_fifo #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_dot4x,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees the slot the write lands in, so a full FIFO still accepts.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_dot4x) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vic_rgb_capture.sv
// Captures the VIC-II RGB stream on pix_ce, tags active pixels with x/y,
// start-of-frame and end-of-run markers, and hands them out over valid/ready.
//   clk_dot4x, rst_n           : clock, asynchronous active-low reset
//   pix_ce                     : sample strobe for all video inputs
//   active, hsync, vsync       : video timing
//   red, green, blue           : pixel colour, 6 bits each
//   out_valid, out_ready       : output handshake
//   out_rgb/x/y/sof/eol        : head pixel fields
//   overflow, drop_count       : sticky drop flag and saturating drop counter
//   frame_count                : vsync edges seen, wrapping
module vic_rgb_capture
    import vic_capture_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic        HSYNC_ACT  = 1'b0,
    parameter logic        VSYNC_ACT  = 1'b0
) (
    input  logic             clk_dot4x,
    input  logic             rst_n,
    input  logic             pix_ce,
    input  logic             active,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [5:0]       red,
    input  logic [5:0]       green,
    input  logic [5:0]       blue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RGB_W-1:0] out_rgb,
    output logic [X_W-1:0]   out_x,
    output logic [Y_W-1:0]   out_y,
    output logic             out_sof,
    output logic             out_eol,
    output logic             overflow,
    output logic [15:0]      drop_count,
    output logic [15:0]      frame_count
);

    // Previous-sample registers hold "asserted" flags, so reset means deasserted.
    logic hs_prev_q, vs_prev_q;
    logic hs_cur, vs_cur;
    logic hs_edge, vs_edge, sync_edge;

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           sof_armed_q, sof_armed_d;

    cap_word_t pend_q, pend_d;
    logic      pend_valid_q, pend_valid_d;

    cap_word_t push_word;
    logic      push_req;
    logic      drop;

    logic        overflow_q;
    logic [15:0] drop_count_q;
    logic [15:0] frame_count_q;

    cap_word_t head;
    logic      fifo_full, fifo_empty;
    logic      pop_fire;

    assign out_valid = ~fifo_empty;
    assign pop_fire  = out_valid & out_ready;

    always_comb begin
        hs_cur    = (hsync == HSYNC_ACT);
        vs_cur    = (vsync == VSYNC_ACT);
        vs_edge   = pix_ce & vs_cur & ~vs_prev_q;
        hs_edge   = pix_ce & hs_cur & ~hs_prev_q;
        sync_edge = vs_edge | hs_edge;

        x_d          = x_q;
        y_d          = y_q;
        sof_armed_d  = sof_armed_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;

        // Every sample retires a pending pixel; it ends its run unless the
        // new sample continues the same run.
        push_req      = pix_ce & pend_valid_q;
        push_word     = pend_q;
        push_word.eol = ~active | sync_edge;

        if (vs_edge) begin
            x_d         = '0;
            y_d         = '0;
            sof_armed_d = 1'b1;
        end else if (hs_edge) begin
            x_d = '0;
            if (y_q != Y_MAX) y_d = y_q + Y_W'(1);
        end

        // Coordinates after any sync edge apply to a pixel on the same sample.
        if (pix_ce) begin
            if (active) begin
                pend_d       = '{sof: sof_armed_d, eol: 1'b0, y: y_d, x: x_d,
                                 rgb: {red, green, blue}};
                pend_valid_d = 1'b1;
                sof_armed_d  = 1'b0;
                if (x_d != X_MAX) x_d = x_d + X_W'(1);
            end else begin
                pend_valid_d = 1'b0;
            end
        end

        drop = push_req & fifo_full & ~pop_fire;
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            sof_armed_q   <= 1'b0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
            drop_count_q  <= '0;
            frame_count_q <= '0;
        end else begin
            if (pix_ce) begin
                hs_prev_q <= hs_cur;
                vs_prev_q <= vs_cur;
            end
            x_q          <= x_d;
            y_q          <= y_d;
            sof_armed_q  <= sof_armed_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
            end
            if (vs_edge) frame_count_q <= frame_count_q + 16'd1;
        end
    end

    cap_sync_fifo #(
        .WIDTH(CAP_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_dot4x(clk_dot4x),
        .rst_n    (rst_n),
        .push     (push_req),
        .din      (push_word),
        .pop      (pop_fire),
        .dout     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_rgb     = head.rgb;
    assign out_x       = head.x;
    assign out_y       = head.y;
    assign out_sof     = head.sof;
    assign out_eol     = head.eol;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;
    assign frame_count = frame_count_q;

endmodule
